// File: rtl/clock_mode_ctrl_if.sv
// Key/event inputs and mode, strobe and display outputs
// of the clock board mode controller.
interface clock_mode_ctrl_if;
  logic [3:0] key_n;
  logic       tick_1hz;
  logic       alarm_en;
  logic       alarm_hit;
  logic       timer_done;
  logic [1:0] mode;
  logic       setting;
  logic [1:0] field;
  logic       inc_pulse;
  logic       run_toggle;
  logic       sw_clear;
  logic [5:0] blank_mask;
  logic       ring;
  logic       ring_src;

  modport master (
    output key_n, tick_1hz, alarm_en,
    output alarm_hit, timer_done,
    input  mode, setting, field,
    input  inc_pulse, run_toggle, sw_clear,
    input  blank_mask, ring, ring_src
  );

  modport slave (
    input  key_n, tick_1hz, alarm_en,
    input  alarm_hit, timer_done,
    output mode, setting, field,
    output inc_pulse, run_toggle, sw_clear,
    output blank_mask, ring, ring_src
  );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Digital clock board controller: key debounce, mode/setting
// FSM, ring arbitration and digit blink mask.
module clock_mode_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BLINK_CYC    = 12500000,
  parameter int RING_TICKS   = 60
) (
  input logic              clk,
  input logic              rst,
  clock_mode_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam int TW = $clog2(RING_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYC - 1);
  localparam logic [TW-1:0] TK_LAST = TW'(RING_TICKS - 1);

  typedef enum logic [2:0] {
    RUN, SET_HOUR, SET_MIN, SET_SEC, RING
  } state_t;

  logic [3:0]    sync1, sync2, db, press;
  logic [DW-1:0] db_cnt [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      press <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= bus.key_n;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db[i]     <= sync2[i];
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // one press per cycle survives: SET > NEXT > MODE > INC
  logic p_set, p_next, p_mode, p_inc, any_press;
  assign p_set     = press[1];
  assign p_next    = press[2] & ~press[1];
  assign p_mode    = press[0] & ~press[1] & ~press[2];
  assign p_inc     = press[3] & ~|press[2:0];
  assign any_press = |press;

  logic alarm_evt, ring_evt;
  assign alarm_evt = bus.alarm_hit & bus.alarm_en;
  assign ring_evt  = alarm_evt | bus.timer_done;

  state_t        state, state_n;
  logic [1:0]    mode_q, mode_n;
  logic          inc_q, inc_n, run_q, run_n;
  logic          clr_q, clr_n, src_q, src_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [5:0]    mask_q, mask_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      mode_q    <= '0;
      inc_q     <= 1'b0;
      run_q     <= 1'b0;
      clr_q     <= 1'b0;
      src_q     <= 1'b0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      mask_q    <= '0;
    end else begin
      state    <= state_n;
      mode_q   <= mode_n;
      inc_q    <= inc_n;
      run_q    <= run_n;
      clr_q    <= clr_n;
      src_q    <= src_n;
      tick_cnt <= tick_n;
      mask_q   <= mask_n;
      // restart the blink visible on every state/field change
      if (state_n != state) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == BL_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    src_n   = src_q;
    tick_n  = tick_cnt;
    inc_n   = 1'b0;
    run_n   = 1'b0;
    clr_n   = 1'b0;
    if (state != RING && ring_evt) begin
      state_n = RING;
      src_n   = ~alarm_evt;
      tick_n  = '0;
    end else begin
      unique case (state)
        RUN: begin
          unique case (1'b1)
            p_set:   if (mode_q != 2'd3) state_n = SET_HOUR;
            p_next:  clr_n = (mode_q == 2'd3);
            p_mode:  mode_n = mode_q + 2'd1;
            p_inc:   run_n = mode_q[1];
            default: ;
          endcase
        end
        SET_HOUR, SET_MIN, SET_SEC: begin
          unique case (1'b1)
            p_set:   state_n = RUN;
            p_next:  state_n = (state == SET_HOUR) ? SET_MIN :
                               (state == SET_MIN)  ? SET_SEC :
                                                     SET_HOUR;
            p_inc:   inc_n = 1'b1;
            default: ;
          endcase
        end
        RING: begin
          if (any_press) begin
            state_n = RUN;
          end else if (bus.tick_1hz) begin
            if (tick_cnt == TK_LAST) state_n = RUN;
            else tick_n = tick_cnt + 1'b1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_comb begin
    mask_n = '0;
    unique case (state)
      SET_HOUR: mask_n = {{2{phase}}, 4'b0};
      SET_MIN:  mask_n = {2'b0, {2{phase}}, 2'b0};
      SET_SEC:  mask_n = {4'b0, {2{phase}}};
      RING:     mask_n = {6{phase}};
      default:  mask_n = '0;
    endcase
  end

  assign bus.mode       = mode_q;
  assign bus.setting    = (state == SET_HOUR) |
                          (state == SET_MIN) |
                          (state == SET_SEC);
  assign bus.field      = (state == SET_HOUR) ? 2'd1 :
                          (state == SET_MIN)  ? 2'd2 :
                          (state == SET_SEC)  ? 2'd3 : 2'd0;
  assign bus.inc_pulse  = inc_q;
  assign bus.run_toggle = run_q;
  assign bus.sw_clear   = clr_q;
  assign bus.blank_mask = mask_q;
  assign bus.ring       = (state == RING);
  assign bus.ring_src   = src_q;
endmodule
